// File: rtl/round_sequencer_if.sv
// Start/stall/abort request and step/round status bundle between the hash FSM and round_sequencer.
// ROUND_SEQ_STALL_CNT_EN adds the stall_cycles status field.
`timescale 1ns/1ps

interface round_sequencer_if #(
   parameter int SW = 3,
   parameter int RW = 6
);
   logic          start;
   logic          stall;
   logic          abort;
   logic          busy;
   logic [1:0]    phase;
   logic [SW-1:0] step_count;
   logic [RW-1:0] round_count;
   logic          last_step;
   logic          round_done;
   logic          rounds_done;
   logic          final_done;
`ifdef ROUND_SEQ_STALL_CNT_EN
   logic [15:0]   stall_cycles;
`endif

   // Hash FSM side: issues requests, observes progress.
   modport master (
      output start, stall, abort,
      input  busy, phase, step_count, round_count, last_step,
      input  round_done, rounds_done, final_done
`ifdef ROUND_SEQ_STALL_CNT_EN
      , input stall_cycles
`endif
   );

   modport slave (
      input  start, stall, abort,
      output busy, phase, step_count, round_count, last_step,
      output round_done, rounds_done, final_done
`ifdef ROUND_SEQ_STALL_CNT_EN
      , output stall_cycles
`endif
   );
endinterface

// File: rtl/round_sequencer.sv
// Step/round tracker for the hash round datapath: IDLE -> ROUNDS -> FINAL with stall and abort.
// ROUND_SEQ_STALL_CNT_EN adds a saturating 16-bit count of stalled busy cycles.
`timescale 1ns/1ps

module round_sequencer #(
   parameter  int STEPS_PER_ROUND = 8,
   parameter  int NUM_ROUNDS      = 36,
   parameter  int FINAL_STEPS     = 8,
   localparam int MAX_STEPS       = (STEPS_PER_ROUND > FINAL_STEPS) ? STEPS_PER_ROUND : FINAL_STEPS,
   localparam int SW              = $clog2(MAX_STEPS),
   localparam int RW              = $clog2(NUM_ROUNDS)
) (
   input  logic              clk,
   input  logic              reset,
   round_sequencer_if.slave  seq
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUNDS = 2'd1,
      FINAL  = 2'd2
   } state_t;

   localparam logic [SW-1:0] ROUND_STEP_LAST = SW'(STEPS_PER_ROUND - 1);
   localparam logic [SW-1:0] FINAL_STEP_LAST = SW'(FINAL_STEPS - 1);
   localparam logic [RW-1:0] ROUND_LAST      = RW'(NUM_ROUNDS - 1);

   state_t        state_q, state_d;
   logic [SW-1:0] step_q, step_d;
   logic [RW-1:0] round_q, round_d;
   logic          busy_q, busy_d;
   logic          round_done_q, round_done_d;
   logic          rounds_done_q, rounds_done_d;
   logic          final_done_q, final_done_d;
   logic          start_accept;

   // Abort outranks stall, and both outrank start, even in IDLE.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d       = state_q;
      step_d        = step_q;
      round_d       = round_q;
      round_done_d  = 1'b0;
      rounds_done_d = 1'b0;
      final_done_d  = 1'b0;
      start_accept  = 1'b0;

      if (seq.abort) begin
         state_d = IDLE;
         step_d  = '0;
         round_d = '0;
      end else if (seq.stall) begin
         // Hold everything; any due done pulse waits for the next advancing cycle.
      end else begin
         unique case (state_q)
            IDLE: begin
               if (seq.start) begin
                  start_accept = 1'b1;
                  state_d      = ROUNDS;
                  step_d       = '0;
                  round_d      = '0;
               end
            end
            ROUNDS: begin
               if (step_q == ROUND_STEP_LAST) begin
                  step_d       = '0;
                  round_done_d = 1'b1;
                  if (round_q == ROUND_LAST) begin
                     state_d       = FINAL;
                     rounds_done_d = 1'b1;
                  end else begin
                     round_d = round_q + RW'(1);
                  end
               end else begin
                  step_d = step_q + SW'(1);
               end
            end
            FINAL: begin
               if (step_q == FINAL_STEP_LAST) begin
                  state_d      = IDLE;
                  step_d       = '0;
                  round_d      = '0;
                  final_done_d = 1'b1;
               end else begin
                  step_d = step_q + SW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               step_d  = '0;
               round_d = '0;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         step_q        <= '0;
         round_q       <= '0;
         busy_q        <= 1'b0;
         round_done_q  <= 1'b0;
         rounds_done_q <= 1'b0;
         final_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         round_q       <= round_d;
         busy_q        <= busy_d;
         round_done_q  <= round_done_d;
         rounds_done_q <= rounds_done_d;
         final_done_q  <= final_done_d;
      end
   end

`ifdef ROUND_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Cleared when a sequence is accepted, frozen once it ends so software can read it afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (start_accept) begin
         stall_cnt_q <= '0;
      end else if (busy_q && seq.stall && !seq.abort && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign seq.stall_cycles = stall_cnt_q;
`else
   logic unused_start_accept;
   assign unused_start_accept = start_accept;
`endif

   assign seq.phase       = state_q;
   assign seq.busy        = busy_q;
   assign seq.step_count  = step_q;
   assign seq.round_count = round_q;
   assign seq.round_done  = round_done_q;
   assign seq.rounds_done = rounds_done_q;
   assign seq.final_done  = final_done_q;

   // Decoded from registers only; IDLE never reports a last step.
   assign seq.last_step = ((state_q == ROUNDS) && (step_q == ROUND_STEP_LAST)) ||
                          ((state_q == FINAL)  && (step_q == FINAL_STEP_LAST));

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: default and small parameter sets, stall, abort, back-to-back, reset.
// Checks stall_cycles as well when ROUND_SEQ_STALL_CNT_EN is defined.
`timescale 1ns/1ps

module tb_round_sequencer;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   round_sequencer_if #(.SW(3), .RW(6)) sif ();
   round_sequencer_if #(.SW(2), .RW(2)) sif2 ();

   round_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .seq   (sif)
   );

   round_sequencer #(
      .STEPS_PER_ROUND (4),
      .NUM_ROUNDS      (3),
      .FINAL_STEPS     (2)
   ) dut_small (
      .clk   (clk),
      .reset (reset),
      .seq   (sif2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packed view: {phase, busy, step, round, last_step, round_done, rounds_done, final_done}
   function automatic logic [31:0] snap1();
      return {16'b0, sif.phase, sif.busy, sif.step_count, sif.round_count,
              sif.last_step, sif.round_done, sif.rounds_done, sif.final_done};
   endfunction

   function automatic logic [31:0] snap2();
      return {21'b0, sif2.phase, sif2.busy, sif2.step_count, sif2.round_count,
              sif2.last_step, sif2.round_done, sif2.rounds_done, sif2.final_done};
   endfunction

   // Expected view for 8 steps x 36 rounds + 8 final steps; cycle 1 is step 0 of round 0.
   function automatic logic [31:0] exp1(input int c);
      logic [1:0] ph;
      logic       bz, ls, rd, rsd, fd;
      logic [2:0] st;
      logic [5:0] rn;
      ph = 2'd0; bz = 1'b0; st = 3'd0; rn = 6'd0; ls = 1'b0; rd = 1'b0; rsd = 1'b0; fd = 1'b0;
      if (c >= 1 && c <= 288) begin
         ph = 2'd1; bz = 1'b1;
         st = 3'((c - 1) % 8);
         rn = 6'((c - 1) / 8);
         ls = (st == 3'd7);
         rd = (c >= 9) && (st == 3'd0);
      end else if (c >= 289 && c <= 296) begin
         ph = 2'd2; bz = 1'b1;
         st = 3'(c - 289);
         rn = 6'd35;
         ls = (st == 3'd7);
         rd = (c == 289);
         rsd = (c == 289);
      end else if (c == 297) begin
         fd = 1'b1;
      end
      return {16'b0, ph, bz, st, rn, ls, rd, rsd, fd};
   endfunction

   // Expected view for 4 steps x 3 rounds + 2 final steps.
   function automatic logic [31:0] exp2(input int c);
      logic [1:0] ph;
      logic       bz, ls, rd, rsd, fd;
      logic [1:0] st;
      logic [1:0] rn;
      ph = 2'd0; bz = 1'b0; st = 2'd0; rn = 2'd0; ls = 1'b0; rd = 1'b0; rsd = 1'b0; fd = 1'b0;
      if (c >= 1 && c <= 12) begin
         ph = 2'd1; bz = 1'b1;
         st = 2'((c - 1) % 4);
         rn = 2'((c - 1) / 4);
         ls = (st == 2'd3);
         rd = (c >= 5) && (st == 2'd0);
      end else if (c >= 13 && c <= 14) begin
         ph = 2'd2; bz = 1'b1;
         st = 2'(c - 13);
         rn = 2'd2;
         ls = (st == 2'd1);
         rd = (c == 13);
         rsd = (c == 13);
      end else if (c == 15) begin
         fd = 1'b1;
      end
      return {21'b0, ph, bz, st, rn, ls, rd, rsd, fd};
   endfunction

   task automatic start_seq();
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
   endtask

   initial begin
      int rd_cnt;
      int prev_rd;
      int m;

      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      sif.start  = 1'b0;
      sif.stall  = 1'b0;
      sif.abort  = 1'b0;
      sif2.start = 1'b0;
      sif2.stall = 1'b0;
      sif2.abort = 1'b0;
      tick();
      tick();
      check("reset state", snap1(), 32'h0);
      check("reset state small", snap2(), 32'h0);
`ifdef ROUND_SEQ_STALL_CNT_EN
      check("reset stall_cycles", 32'(sif.stall_cycles), 32'h0);
`endif
      reset = 1'b0;
      tick();
      check("idle without start", snap1(), 32'h0);

      // Full run without stalls.
      start_seq();
      rd_cnt = 0;
      for (int c = 1; c <= 297; c++) begin
         check($sformatf("full c%0d", c), snap1(), exp1(c));
         if (sif.round_done) rd_cnt++;
         if (c < 297) tick();
      end
      check("round_done count", 32'(rd_cnt), 32'd36);
      tick();
      check("idle after full run", snap1(), 32'h0);

      // Stall for 5 cycles at round 3, step 4 (cycle 29).
      start_seq();
      for (int c = 1; c <= 302; c++) begin
         m = (c <= 29) ? c : ((c <= 34) ? 29 : c - 5);
         check($sformatf("stall c%0d", c), snap1(), exp1(m));
         sif.stall = (c >= 29 && c <= 33);
         if (c < 302) tick();
      end
      sif.stall = 1'b0;
`ifdef ROUND_SEQ_STALL_CNT_EN
      check("stall_cycles at end", 32'(sif.stall_cycles), 32'd5);
`endif
      tick();
      tick();
      check("idle after stall run", snap1(), 32'h0);
`ifdef ROUND_SEQ_STALL_CNT_EN
      check("stall_cycles held", 32'(sif.stall_cycles), 32'd5);
`endif

      // Abort together with start at round 20, step 2 (cycle 163).
      start_seq();
`ifdef ROUND_SEQ_STALL_CNT_EN
      check("stall_cycles cleared on start", 32'(sif.stall_cycles), 32'd0);
`endif
      for (int c = 1; c <= 163; c++) begin
         check($sformatf("abort c%0d", c), snap1(), exp1(c));
         if (c < 163) tick();
      end
      sif.abort = 1'b1;
      sif.start = 1'b1;
      tick();
      sif.abort = 1'b0;
      sif.start = 1'b0;
      check("abort next cycle", snap1(), 32'h0);
      tick();
      check("abort no restart", snap1(), 32'h0);
      tick();
      check("abort still idle", snap1(), 32'h0);

      // Back-to-back: start in the final_done cycle.
      start_seq();
      for (int c = 1; c <= 297; c++) begin
         check($sformatf("b2b first c%0d", c), snap1(), exp1(c));
         if (c < 297) tick();
      end
      start_seq();
      prev_rd = 0;
      for (int c = 1; c <= 297; c++) begin
         check($sformatf("b2b second c%0d", c), snap1(), exp1(c));
         if (sif.round_done) begin
            if (prev_rd != 0) check($sformatf("b2b spacing c%0d", c), 32'(c - prev_rd), 32'd8);
            prev_rd = c;
         end
         if (c < 297) tick();
      end
      tick();

      // Reset at step 5 of the final phase (cycle 294).
      start_seq();
      for (int c = 1; c <= 294; c++) begin
         check($sformatf("rst c%0d", c), snap1(), exp1(c));
         if (c < 294) tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset mid final", snap1(), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("after reset %0d", i), snap1(), 32'h0);
      end

      // Small parameter set, with an extra start pulse while busy at cycle 6.
      sif2.start = 1'b1;
      tick();
      sif2.start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         check($sformatf("small c%0d", c), snap2(), exp2(c));
         sif2.start = (c == 6);
         if (c < 16) tick();
      end
      sif2.start = 1'b0;
      tick();
      check("small idle", snap2(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
